// File: rtl/game_flow_sequencer.sv
// game_flow_sequencer: screen-flow FSM with key edge detection, game core run/clear control
// and a registered VGA mux over five screen sources (PAUSE shows a half-brightness PLAY frame).
module game_flow_sequencer #(
  parameter int COLOR_W = 4,
  parameter int LEVELS = 4,
  parameter int END_TIMEOUT = 500_000_000,
  localparam int LEVEL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_space,
  input  logic                   key_esc,
  input  logic                   key_p,
  input  logic                   win,
  input  logic                   lose,
  input  logic [4:0]             hsync_in,
  input  logic [4:0]             vsync_in,
  input  logic [5*COLOR_W-1:0]   red_in,
  input  logic [5*COLOR_W-1:0]   green_in,
  input  logic [5*COLOR_W-1:0]   blue_in,
  output logic                   hsync,
  output logic                   vsync,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic [2:0]             screen,
  output logic                   game_run,
  output logic                   game_clear,
  output logic [LEVEL_W-1:0]     level
);
  localparam int TIMER_W = (END_TIMEOUT > 0) ? $clog2(END_TIMEOUT + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((END_TIMEOUT > 0) ? END_TIMEOUT - 1 : 0);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(LEVELS - 1);
  typedef enum logic [2:0] {
    S_START    = 3'd0,
    S_PLAY     = 3'd1,
    S_PAUSE    = 3'd2,
    S_LEVEL_UP = 3'd3,
    S_WIN      = 3'd4,
    S_LOSE     = 3'd5
  } state_t;
  state_t r_state, w_next;
  logic r_space_q, r_esc_q, r_p_q;
  logic [TIMER_W-1:0] r_timer;
  logic w_space_rise, w_esc_rise, w_p_rise, w_timeout, w_clear, w_end, w_pause;
  logic [2:0] w_src;
  logic [COLOR_W-1:0] w_red, w_green, w_blue;
  assign w_space_rise = key_space & ~r_space_q;
  assign w_esc_rise = key_esc & ~r_esc_q;
  assign w_p_rise = key_p & ~r_p_q;
  assign w_end = (r_state == S_LEVEL_UP) || (r_state == S_WIN) || (r_state == S_LOSE);
  assign w_timeout = (END_TIMEOUT != 0) && (r_timer == TIMER_LAST);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_START:     w_next = w_space_rise ? S_PLAY : S_START;
      S_PLAY:      w_next = lose ? S_LOSE
                          : win ? ((level == LEVEL_LAST) ? S_WIN : S_LEVEL_UP)
                          : w_esc_rise ? S_START
                          : w_p_rise ? S_PAUSE : S_PLAY;
      S_PAUSE:     w_next = w_esc_rise ? S_START : (w_p_rise | w_space_rise) ? S_PLAY : S_PAUSE;
      S_LEVEL_UP:  w_next = (w_space_rise | w_timeout) ? S_PLAY : S_LEVEL_UP;
      S_WIN:       w_next = (w_esc_rise | w_space_rise | w_timeout) ? S_START : S_WIN;
      S_LOSE:      w_next = (w_esc_rise | w_space_rise | w_timeout) ? S_START : S_LOSE;
      default:     w_next = S_START;
    endcase
  end
  assign w_clear = (w_next == S_PLAY) && ((r_state == S_START) || (r_state == S_LEVEL_UP));
  // PLAY and PAUSE share source 1; END screens map to sources 2..4
  assign w_src = (r_state == S_PLAY || r_state == S_PAUSE) ? 3'd1
               : (r_state == S_LEVEL_UP) ? 3'd2
               : (r_state == S_WIN) ? 3'd3
               : (r_state == S_LOSE) ? 3'd4 : 3'd0;
  assign w_pause = r_state == S_PAUSE;
  assign w_red = red_in[w_src*COLOR_W +: COLOR_W] >> w_pause;
  assign w_green = green_in[w_src*COLOR_W +: COLOR_W] >> w_pause;
  assign w_blue = blue_in[w_src*COLOR_W +: COLOR_W] >> w_pause;
  assign screen = r_state;
  always_ff @(posedge clk) begin
    r_space_q <= key_space;
    r_esc_q <= key_esc;
    r_p_q <= key_p;
    if (reset) begin
      r_state <= S_START;
      level <= '0;
      game_run <= 1'b0;
      game_clear <= 1'b0;
      r_timer <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      red <= '0;
      green <= '0;
      blue <= '0;
    end else begin
      r_state <= w_next;
      game_run <= w_next == S_PLAY;
      game_clear <= w_clear;
      if (w_clear) level <= (r_state == S_START) ? '0 : level + 1'b1;
      r_timer <= (w_next != r_state) ? '0 : (w_end && r_timer != '1) ? r_timer + 1'b1 : r_timer;
      hsync <= hsync_in[w_src];
      vsync <= vsync_in[w_src];
      red <= w_red;
      green <= w_green;
      blue <= w_blue;
    end
  end
endmodule

// File: tb/tb_game_flow_sequencer.sv
// tb_game_flow_sequencer: directed and random stimulus scored against a screen-level reference model.
module tb_game_flow_sequencer;
  localparam int CW = 4;
  localparam int LV = 2;
  localparam int TO = 8;
  localparam int LW = (LV > 1) ? $clog2(LV) : 1;
  localparam int VW = 5 * CW;
  logic clk = 0, reset = 1, key_space = 0, key_esc = 0, key_p = 0, win = 0, lose = 0;
  logic [4:0] hsync_in = '0, vsync_in = '0;
  logic [VW-1:0] red_in = '0, green_in = '0, blue_in = '0;
  logic hsync, vsync, game_run, game_clear;
  logic [CW-1:0] red, green, blue;
  logic [2:0] screen;
  logic [LW-1:0] level;
  typedef struct packed {
    logic [2:0] scr;
    logic [LW-1:0] lvl;
    logic run, clr, hs, vs;
    logic [CW-1:0] r, g, b;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int m_scr = 0, m_lvl = 0, m_cnt = 0;
  bit m_sq = 0, m_eq = 0, m_pq = 0;
  bit force_red = 0;

  game_flow_sequencer #(.COLOR_W(CW), .LEVELS(LV), .END_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .key_space(key_space), .key_esc(key_esc), .key_p(key_p),
    .win(win), .lose(lose), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .screen(screen), .game_run(game_run), .game_clear(game_clear), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask

  // drive one cycle of inputs and predict the outputs after the following clock edge
  task automatic cycle(input bit rs, input bit sp, input bit es, input bit pk, input bit w, input bit l);
    exp_t e;
    int ns, nl, src;
    bit sr, er, pr, tmo;
    @(negedge clk);
    reset = rs; key_space = sp; key_esc = es; key_p = pk; win = w; lose = l;
    hsync_in = 5'($urandom); vsync_in = 5'($urandom);
    red_in = VW'($urandom); green_in = VW'($urandom); blue_in = VW'($urandom);
    if (force_red) red_in[2*CW-1:CW] = '1;
    sr = sp && !m_sq; er = es && !m_eq; pr = pk && !m_pq;
    m_sq = sp; m_eq = es; m_pq = pk;
    e = '0;
    if (rs) begin
      m_scr = 0; m_lvl = 0; m_cnt = 0;
      e.hs = 1; e.vs = 1;
    end else begin
      src = (m_scr == 0) ? 0 : (m_scr <= 2) ? 1 : m_scr - 1;
      e.hs = hsync_in[src]; e.vs = vsync_in[src];
      e.r = red_in[src*CW +: CW]; e.g = green_in[src*CW +: CW]; e.b = blue_in[src*CW +: CW];
      if (m_scr == 2) begin
        e.r = e.r / 2; e.g = e.g / 2; e.b = e.b / 2;
      end
      ns = m_scr; nl = m_lvl;
      tmo = (TO != 0) && (m_cnt == TO - 1);
      case (m_scr)
        0: begin if (sr) begin ns = 1; nl = 0; e.clr = 1; end end
        1: begin
          if (l) ns = 5;
          else if (w) ns = (m_lvl == LV - 1) ? 4 : 3;
          else if (er) ns = 0;
          else if (pr) ns = 2;
        end
        2: begin if (er) ns = 0; else if (pr || sr) ns = 1; end
        3: begin if (sr || tmo) begin ns = 1; nl = m_lvl + 1; e.clr = 1; end end
        default: begin if (er || sr || tmo) ns = 0; end
      endcase
      m_cnt = (ns == m_scr) ? m_cnt + 1 : 0;
      m_scr = ns; m_lvl = nl;
      e.run = ns == 1;
    end
    e.scr = 3'(m_scr);
    e.lvl = LW'(m_lvl);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("screen", 32'(screen), 32'(e.scr));
        chk("level", 32'(level), 32'(e.lvl));
        chk("game_run", 32'(game_run), 32'(e.run));
        chk("game_clear", 32'(game_clear), 32'(e.clr));
        chk("video", {hsync, vsync, red, green, blue}, {e.hs, e.vs, e.r, e.g, e.b});
      end
    end
  end

  initial begin
    repeat (3) cycle(1, 0, 0, 0, 0, 0);
    idle(2);
    cycle(0, 1, 0, 0, 0, 0); idle(3);
    force_red = 1;
    cycle(0, 0, 0, 1, 0, 0); idle(3);
    cycle(0, 0, 0, 1, 0, 0); idle(2);
    force_red = 0;
    cycle(0, 0, 0, 0, 1, 0); idle(2);
    cycle(0, 1, 0, 0, 0, 0); idle(2);
    cycle(0, 0, 0, 0, 1, 0); idle(11);
    cycle(0, 1, 0, 0, 0, 0); idle(2);
    cycle(0, 0, 0, 0, 1, 1); idle(11);
    repeat (2) cycle(1, 1, 0, 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 0, 0, 0);
    idle(1);
    cycle(0, 1, 0, 0, 0, 0); idle(2);
    cycle(0, 0, 0, 0, 1, 0); idle(3);
    cycle(1, 1, 0, 1, 1, 0); idle(2);
    repeat (3000)
      cycle($urandom_range(0, 299) == 0,
            ($urandom_range(0, 7) == 0) ? !key_space : key_space,
            ($urandom_range(0, 15) == 0) ? !key_esc : key_esc,
            ($urandom_range(0, 7) == 0) ? !key_p : key_p,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 31) == 0);
    repeat (2) @(posedge clk);
    #3;
    chk("drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
